// File: rtl/shift_rotate_sequencer_pkg.sv
// Shared definitions for the shift/rotate sequencer.
//   - op encodings (OP_SHR..OP_ROL), FSM state encoding
//   - WIDTH_LOG2 / CNT_W: the remaining counter needs one extra bit so 32 fits
//   - helpers: op legality, effective step count, one single-bit step
package shift_rotate_sequencer_pkg;

  localparam int DATA_W     = 32;
  localparam int WIDTH_LOG2 = 5;
  localparam int CNT_W      = WIDTH_LOG2 + 1;

  typedef enum logic [2:0] {
    OP_SHR  = 3'b000,
    OP_SHRA = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

  // Rotates wrap modulo 32; shifts saturate at 32 so large amounts fully
  // drain the word (zeros, or sign copies for SHRA). Illegal ops do nothing.
  function automatic logic [CNT_W-1:0] effective_count(logic [2:0] op, logic [31:0] amount);
    logic [CNT_W-1:0] n;
    n = '0;
    case (op)
      OP_ROR, OP_ROL:          n = {1'b0, amount[WIDTH_LOG2-1:0]};
      OP_SHR, OP_SHRA, OP_SHL: n = (|amount[31:WIDTH_LOG2]) ? CNT_W'(DATA_W)
                                                             : {1'b0, amount[WIDTH_LOG2-1:0]};
      default:                 n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] single_step(logic [DATA_W-1:0] w, logic [2:0] op);
    logic [DATA_W-1:0] r;
    r = w;
    case (op)
      OP_SHR:  r = {1'b0, w[DATA_W-1:1]};
      OP_SHRA: r = {w[DATA_W-1], w[DATA_W-1:1]};
      OP_SHL:  r = {w[DATA_W-2:0], 1'b0};
      OP_ROR:  r = {w[0], w[DATA_W-1:1]};
      OP_ROL:  r = {w[DATA_W-2:0], w[DATA_W-1]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_rotate_sequencer_if.sv
// Handshake bundle between the control unit (master) and the sequencer (slave).
//   start/op/data_in/amount : request, driven by master
//   result/busy/done/illegal: completion, driven by slave
interface shift_rotate_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [31:0]      amount;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (output start, op, data_in, amount,
                  input  result, busy, done, illegal);
  modport slave  (input  start, op, data_in, amount,
                  output result, busy, done, illegal);
endinterface

// File: rtl/shift_rotate_sequencer_shift_step.sv
// shift_step: combinational shifter that applies k (0..STEP) single-bit
// steps of the given op to word.
//   word   in  WIDTH  working value
//   op     in  3      operation code
//   k      in  CNT_W  number of steps to apply this cycle
//   result out WIDTH  word after k steps
module shift_step
  import shift_rotate_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] word,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] k,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] acc;

  // Chain of STEP single-bit stages; stage i is bypassed when i >= k.
  always_comb begin
    acc = word;
    for (int i = 0; i < STEP; i++) begin
      if (CNT_W'(i) < k) acc = single_step(acc, op);
    end
    result = acc;
  end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// shift_rotate_sequencer: multi-cycle SHR/SHRA/SHL/ROR/ROL engine that
// iterates a STEP-bit shifter until the requested count is consumed.
//   clk    in  system clock, rising edge
//   clear  in  asynchronous active-high reset (aborts any operation)
//   bus    slave side of shift_rotate_sequencer_if
//            start/op/data_in/amount captured at the accepting edge in IDLE
//            result held until next completion; busy from accept through
//            done; done one-cycle pulse; illegal with done for op 101..111
// WIDTH must be 32; STEP may be 1, 2, 4, 8 or 16.
module shift_rotate_sequencer
  import shift_rotate_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                    clk,
  input  logic                    clear,
  shift_rotate_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

  state_e           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] result_reg;
  logic [2:0]       op_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             illegal_reg;

  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] start_count;
  logic [WIDTH-1:0] stepped;

  assign start_count = effective_count(bus.op, bus.amount);
  // Final partial step when fewer than STEP bits remain.
  assign k = (remaining_reg < STEP_CNT) ? remaining_reg : STEP_CNT;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift_step (
    .word   (work_reg),
    .op     (op_reg),
    .k      (k),
    .result (stepped)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg     <= ST_IDLE;
      work_reg      <= '0;
      result_reg    <= '0;
      op_reg        <= '0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            work_reg      <= bus.data_in;
            op_reg        <= bus.op;
            remaining_reg <= start_count;
            busy_reg      <= 1'b1;
            if (start_count == '0) begin
              // Nothing to shift (amount 0 or illegal op): complete at once.
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              result_reg  <= bus.data_in;
              illegal_reg <= ~op_is_legal(bus.op);
            end else begin
              state_reg   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          work_reg      <= stepped;
          remaining_reg <= remaining_reg - k;
          if (remaining_reg == k) begin
            state_reg  <= ST_DONE;
            done_reg   <= 1'b1;
            result_reg <= stepped;
          end
        end
        ST_DONE: begin
          state_reg   <= ST_IDLE;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          illegal_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result  = result_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.illegal = illegal_reg;

endmodule
